rice_core_bus_arbiter: RTL and testbench
========================================

# rice_core_bus_arbiter

Shares a single memory bus port between the core's instruction fetch and its load/store unit, one transaction at a time. For data accesses it also generates byte strobes and aligns write data from the memory access descriptor. It extracts and sign- or zero-extends load data, and returns misaligned or illegal accesses as errors without issuing them to the bus. It sits between the fetch/execute stages and the external memory interface.

## Interface
- ADDRESS_WIDTH, 32, byte address width of all ports; data width is fixed at 32
- Clock and reset: one clock; reset is synchronous and active-low.
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_fetch_valid / o_fetch_ready  in/out  1  fetch request handshake
- i_fetch_address  in  ADDRESS_WIDTH  fetch byte address
- o_fetch_response_valid  out  1  one-cycle fetch response strobe
- o_fetch_data  out  32  instruction word
- o_fetch_error  out  1  fetch failed: misaligned or bus error
- i_data_valid / o_data_ready  in/out  1  data request handshake
- i_data_address  in  ADDRESS_WIDTH  data byte address
- i_data_access  in  rice_core_memory_access  access type (store/load) and mode (B/BU/H/HU/W)
- i_data_write_data  in  32  store data, right-justified
- o_data_response_valid  out  1  one-cycle data response strobe
- o_data_read_data  out  32  extended load data; 0 for stores
- o_data_error  out  1  data access failed
- o_bus_valid / i_bus_ready  out/in  1  bus request handshake
- o_bus_address  out  ADDRESS_WIDTH  word-aligned address (bits [1:0] = 0)
- o_bus_write  out  1  1 = store
- o_bus_strobe  out  4  byte enables
- o_bus_write_data  out  32  lane-replicated store data
- i_bus_response_valid  in  1  bus response strobe; cannot be back-pressured
- i_bus_read_data  in  32  raw read word
- i_bus_error  in  1  bus error, qualified by i_bus_response_valid

## Operation
- FSM states: IDLE, REQUEST, RESPONSE, ERROR. Reset state is IDLE.
- Transaction limit: at most one transaction outstanding overall.
- IDLE:
  - Arbitrate among valid requesters.
  - o_X_ready is combinational and is 1 only for the winner, only in IDLE.
  - On accept, register the address and access attributes and tag the owner.
  - Go to ERROR if the access is illegal, otherwise to REQUEST.
- Illegal accesses:
  - Misaligned: fetch address[1:0]≠0; H/HU with address[0]≠0; W with address[1:0]≠0.
  - access_type NONE.
  - Undefined access_mode encodings: 011, 110, 111.
- REQUEST: o_bus_valid=1 with stable attributes until i_bus_ready. Then go to RESPONSE.
- RESPONSE:
  - On i_bus_response_valid, register the processed data and error for the owner and go to IDLE.
  - The owner's response_valid fires in the next cycle.
- ERROR: owner's response_valid=1 and error=1 with data 0 for one cycle, then go to IDLE. No bus activity.
- Strobes by mode:
  - B/BU: 1<<addr[1:0].
  - H/HU: 0011 or 1100.
  - W: 1111.
  - Fetch: 1111 read.
- Write data: byte replicated to all 4 lanes; half replicated to both halves; word as-is.
- Load data: select the lane by addr[1:0]. B/H are sign-extended; BU/HU are zero-extended. Fetch returns the raw word.
- Reset values: all outputs 0. A reset mid-transaction drops the transaction and returns to IDLE with no response. The bus slave is reset by the same i_rst_n.

## Timing
- Accept in cycle N → o_bus_valid from N+1.
- Bus response in cycle M → requester response in M+1.
- Minimum round trip: request accepted in N, i_bus_ready in N+1, bus response in N+2, requester response in N+3.
- A new request can be accepted in the same cycle as the previous response strobe (state is IDLE then).
- Requests arriving simultaneously are resolved per Configuration. The loser sees ready=0 and must hold its request.
- Illegal access: accept in N → error response in N+1.

## Configuration
- RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN
  - Defined: round-robin. When both request, the requester not granted last wins. The last-grant register resets to fetch, so data wins first.
  - Undefined: fixed priority, data over fetch.

## Structure
- Shared package rice_core_pkg gains:
  - rice_core_bus_arbiter_state enum.
  - rice_core_bus_owner enum (FETCH, DATA).
  - Strobe and extension helper functions.
  - The package already holds rice_core_memory_access and its mode encodings.
- Sub-module rice_core_bus_data_aligner: purely combinational; strobe generation, write replication and load extraction.

## Test plan
- Fetch 0x100 alone, bus ready at once, read 0xDEADBEEF → o_bus_address 0x100, strobe 1111; o_fetch_data 0xDEADBEEF 3 cycles after accept.
- LB at 0x203, bus word 0x80FFFFFF → strobe 1000; read_data 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH of 0x1234 at 0x402 → write=1, strobe 1100, write_data 0x12341234; data response with read_data 0.
- LW at 0x401 → error response the next cycle with data 0; o_bus_valid never asserted.
- Fetch and data both valid continuously for 4 transactions:
  - Fixed priority: all 4 go to data.
  - With RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN: data, fetch, data, fetch.
- Reset asserted while in RESPONSE → all outputs 0 the next cycle and no response. A fresh fetch after reset completes normally; i_bus_error=1 then yields o_fetch_error=1.

Source files
------------

// File: rtl/rice_core_pkg.sv
// Shared core package: memory access descriptor, bus arbiter state and
// owner types, plus strobe, replication, extension and legality helpers.
package rice_core_pkg;

    typedef enum logic [1:0] {
        ACCESS_NONE  = 2'b00,
        ACCESS_LOAD  = 2'b01,
        ACCESS_STORE = 2'b10
    } rice_core_access_type;

    // Encodings 011, 110 and 111 are undefined and rejected as illegal.
    typedef enum logic [2:0] {
        MODE_B  = 3'b000,
        MODE_H  = 3'b001,
        MODE_W  = 3'b010,
        MODE_BU = 3'b100,
        MODE_HU = 3'b101
    } rice_core_access_mode;

    typedef struct packed {
        rice_core_access_type access_type;
        rice_core_access_mode access_mode;
    } rice_core_memory_access;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'b00,
        ARB_REQUEST  = 2'b01,
        ARB_RESPONSE = 2'b10,
        ARB_ERROR    = 2'b11
    } rice_core_bus_arbiter_state;

    typedef enum logic {
        BUS_OWNER_FETCH = 1'b0,
        BUS_OWNER_DATA  = 1'b1
    } rice_core_bus_owner;

    // Byte enables for an access of the given size at the given byte offset.
    function automatic logic [3:0] access_strobe(input rice_core_access_mode mode,
                                                 input logic [1:0] offset);
        case (mode)
            MODE_B, MODE_BU: access_strobe = 4'b0001 << offset;
            MODE_H, MODE_HU: access_strobe = offset[1] ? 4'b1100 : 4'b0011;
            MODE_W:          access_strobe = 4'b1111;
            default:         access_strobe = 4'b0000;
        endcase
    endfunction

    // Replicate right-justified store data across every lane it may occupy.
    function automatic logic [31:0] write_replicate(input rice_core_access_mode mode,
                                                    input logic [31:0] data);
        case (mode)
            MODE_B, MODE_BU: write_replicate = {4{data[7:0]}};
            MODE_H, MODE_HU: write_replicate = {2{data[15:0]}};
            default:         write_replicate = data;
        endcase
    endfunction

    // Pick the addressed lane out of a raw word and sign- or zero-extend it.
    function automatic logic [31:0] load_extend(input rice_core_access_mode mode,
                                                input logic [1:0] offset,
                                                input logic [31:0] word);
        logic [31:0] shifted;
        logic [15:0] half;
        shifted = word >> {offset, 3'b000};
        half    = offset[1] ? word[31:16] : word[15:0];
        case (mode)
            MODE_B:  load_extend = {{24{shifted[7]}}, shifted[7:0]};
            MODE_BU: load_extend = {24'h0, shifted[7:0]};
            MODE_H:  load_extend = {{16{half[15]}}, half};
            MODE_HU: load_extend = {16'h0, half};
            default: load_extend = word;
        endcase
    endfunction

    // A data access is illegal if it has no type, an undefined mode, or is
    // misaligned for its size.
    function automatic logic access_illegal(input rice_core_memory_access access,
                                            input logic [1:0] offset);
        logic bad_type;
        bad_type = (access.access_type != ACCESS_LOAD) &&
                   (access.access_type != ACCESS_STORE);
        case (access.access_mode)
            MODE_B, MODE_BU: access_illegal = bad_type;
            MODE_H, MODE_HU: access_illegal = bad_type || offset[0];
            MODE_W:          access_illegal = bad_type || (offset != 2'b00);
            default:         access_illegal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/rice_core_bus_data_aligner.sv
// Combinational lane logic for the bus arbiter: strobes and write-data
// replication on the request side, lane extraction on the response side.
module rice_core_bus_data_aligner
    import rice_core_pkg::*;
(
    input  rice_core_access_mode req_mode,
    input  logic [1:0]           req_offset,
    input  logic [31:0]          req_write_data,
    output logic [3:0]           req_strobe,
    output logic [31:0]          req_aligned_data,
    input  rice_core_access_mode rsp_mode,
    input  logic [1:0]           rsp_offset,
    input  logic [31:0]          rsp_read_data,
    output logic [31:0]          rsp_load_data
);

    // Request lanes and response extraction are independent pure functions.
    always_comb begin
        req_strobe       = access_strobe(req_mode, req_offset);
        req_aligned_data = write_replicate(req_mode, req_write_data);
        rsp_load_data    = load_extend(rsp_mode, rsp_offset, rsp_read_data);
    end

endmodule

// File: rtl/rice_core_bus_arbiter.sv
// Single-port bus arbiter between instruction fetch and load/store.
// One transaction outstanding; illegal data or misaligned fetch accesses
// are answered with an error without touching the bus.
// Build option: RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN selects round-robin
// arbitration; otherwise data has fixed priority over fetch.
module rice_core_bus_arbiter
    import rice_core_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_fetch_valid,
    output logic                     o_fetch_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_fetch_address,
    output logic                     o_fetch_response_valid,
    output logic [31:0]              o_fetch_data,
    output logic                     o_fetch_error,
    input  logic                     i_data_valid,
    output logic                     o_data_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_data_address,
    input  rice_core_memory_access   i_data_access,
    input  logic [31:0]              i_data_write_data,
    output logic                     o_data_response_valid,
    output logic [31:0]              o_data_read_data,
    output logic                     o_data_error,
    output logic                     o_bus_valid,
    input  logic                     i_bus_ready,
    output logic [ADDRESS_WIDTH-1:0] o_bus_address,
    output logic                     o_bus_write,
    output logic [3:0]               o_bus_strobe,
    output logic [31:0]              o_bus_write_data,
    input  logic                     i_bus_response_valid,
    input  logic [31:0]              i_bus_read_data,
    input  logic                     i_bus_error
);

    rice_core_bus_arbiter_state state;
    rice_core_bus_owner         owner;
    rice_core_access_mode       reg_mode;
    logic [1:0]                 reg_offset;
    logic                       reg_store;

    logic                       grant_fetch;
    logic                       grant_data;
    logic [ADDRESS_WIDTH-1:0]   req_address;
    rice_core_access_mode       req_mode;
    logic                       req_store;
    logic                       req_illegal;
    logic [3:0]                 req_strobe;
    logic [31:0]                req_aligned_data;
    logic [31:0]                rsp_load_data;
    logic [31:0]                rsp_data;

`ifdef RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN
    rice_core_bus_owner last_grant;

    // Remember who was granted last so a contested grant alternates.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_grant <= BUS_OWNER_FETCH;
        end else if (grant_data) begin
            last_grant <= BUS_OWNER_DATA;
        end else if (grant_fetch) begin
            last_grant <= BUS_OWNER_FETCH;
        end
    end
`endif

    // Grant at most one requester, and only while idle and out of reset.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (i_rst_n && state == ARB_IDLE) begin
`ifdef RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN
            if (i_fetch_valid && i_data_valid) begin
                grant_data  = (last_grant == BUS_OWNER_FETCH);
                grant_fetch = (last_grant == BUS_OWNER_DATA);
            end else begin
                grant_data  = i_data_valid;
                grant_fetch = i_fetch_valid;
            end
`else
            grant_data  = i_data_valid;
            grant_fetch = i_fetch_valid && !i_data_valid;
`endif
        end
    end

    assign o_fetch_ready = grant_fetch;
    assign o_data_ready  = grant_data;

    // Attributes of the winning request; fetch behaves as an aligned word read.
    always_comb begin
        req_address = i_fetch_address;
        req_mode    = MODE_W;
        req_store   = 1'b0;
        req_illegal = (i_fetch_address[1:0] != 2'b00);
        if (grant_data) begin
            req_address = i_data_address;
            req_mode    = i_data_access.access_mode;
            req_store   = (i_data_access.access_type == ACCESS_STORE);
            req_illegal = access_illegal(i_data_access, i_data_address[1:0]);
        end
    end

    rice_core_bus_data_aligner u_aligner (
        .req_mode         (req_mode),
        .req_offset       (req_address[1:0]),
        .req_write_data   (i_data_write_data),
        .req_strobe       (req_strobe),
        .req_aligned_data (req_aligned_data),
        .rsp_mode         (reg_mode),
        .rsp_offset       (reg_offset),
        .rsp_read_data    (i_bus_read_data),
        .rsp_load_data    (rsp_load_data)
    );

    // Stores and failed accesses return zero data.
    assign rsp_data = (reg_store || i_bus_error) ? 32'h0 : rsp_load_data;

    // Transaction FSM with every bus and response output registered.
    always_ff @(posedge i_clk) begin
        // NOTE: datapath registers are reset as well so every output reads 0
        // straight out of reset, and a reset mid-transaction leaves nothing behind.
        if (!i_rst_n) begin
            state                  <= ARB_IDLE;
            owner                  <= BUS_OWNER_FETCH;
            reg_mode               <= MODE_W;
            reg_offset             <= 2'b00;
            reg_store              <= 1'b0;
            o_bus_valid            <= 1'b0;
            o_bus_address          <= '0;
            o_bus_write            <= 1'b0;
            o_bus_strobe           <= 4'b0000;
            o_bus_write_data       <= 32'h0;
            o_fetch_response_valid <= 1'b0;
            o_fetch_data           <= 32'h0;
            o_fetch_error          <= 1'b0;
            o_data_response_valid  <= 1'b0;
            o_data_read_data       <= 32'h0;
            o_data_error           <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so the response
            // strobes below can default low and be overridden in the same cycle.
            o_fetch_response_valid <= 1'b0;
            o_data_response_valid  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_fetch || grant_data) begin
                        owner      <= grant_data ? BUS_OWNER_DATA : BUS_OWNER_FETCH;
                        reg_mode   <= req_mode;
                        reg_offset <= req_address[1:0];
                        reg_store  <= req_store;
                        if (req_illegal) begin
                            state <= ARB_ERROR;
                            if (grant_data) begin
                                o_data_response_valid <= 1'b1;
                                o_data_read_data      <= 32'h0;
                                o_data_error          <= 1'b1;
                            end else begin
                                o_fetch_response_valid <= 1'b1;
                                o_fetch_data           <= 32'h0;
                                o_fetch_error          <= 1'b1;
                            end
                        end else begin
                            state            <= ARB_REQUEST;
                            o_bus_valid      <= 1'b1;
                            o_bus_address    <= {req_address[ADDRESS_WIDTH-1:2], 2'b00};
                            o_bus_write      <= req_store;
                            o_bus_strobe     <= req_strobe;
                            o_bus_write_data <= req_store ? req_aligned_data : 32'h0;
                        end
                    end
                end
                ARB_REQUEST: begin
                    if (i_bus_ready) begin
                        o_bus_valid <= 1'b0;
                        state       <= ARB_RESPONSE;
                    end
                end
                ARB_RESPONSE: begin
                    if (i_bus_response_valid) begin
                        state <= ARB_IDLE;
                        if (owner == BUS_OWNER_DATA) begin
                            o_data_response_valid <= 1'b1;
                            o_data_read_data      <= rsp_data;
                            o_data_error          <= i_bus_error;
                        end else begin
                            o_fetch_response_valid <= 1'b1;
                            o_fetch_data           <= rsp_data;
                            o_fetch_error          <= i_bus_error;
                        end
                    end
                end
                ARB_ERROR: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rice_core_bus_arbiter.sv
// Directed testbench for rice_core_bus_arbiter. Expected arbitration order
// follows RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN when defined.
module tb_rice_core_bus_arbiter;
    import rice_core_pkg::*;

    logic                   i_clk = 1'b0;
    logic                   i_rst_n;
    logic                   i_fetch_valid;
    logic                   o_fetch_ready;
    logic [31:0]            i_fetch_address;
    logic                   o_fetch_response_valid;
    logic [31:0]            o_fetch_data;
    logic                   o_fetch_error;
    logic                   i_data_valid;
    logic                   o_data_ready;
    logic [31:0]            i_data_address;
    rice_core_memory_access i_data_access;
    logic [31:0]            i_data_write_data;
    logic                   o_data_response_valid;
    logic [31:0]            o_data_read_data;
    logic                   o_data_error;
    logic                   o_bus_valid;
    logic                   i_bus_ready;
    logic [31:0]            o_bus_address;
    logic                   o_bus_write;
    logic [3:0]             o_bus_strobe;
    logic [31:0]            o_bus_write_data;
    logic                   i_bus_response_valid;
    logic [31:0]            i_bus_read_data;
    logic                   i_bus_error;

    int n_pass  = 0;
    int n_total = 0;

    // Raw descriptor encodings {type[1:0], mode[2:0]}.
    localparam logic [4:0] ACC_LB  = 5'b01_000;
    localparam logic [4:0] ACC_LBU = 5'b01_100;
    localparam logic [4:0] ACC_LH  = 5'b01_001;
    localparam logic [4:0] ACC_LHU = 5'b01_101;
    localparam logic [4:0] ACC_LW  = 5'b01_010;
    localparam logic [4:0] ACC_SB  = 5'b10_000;
    localparam logic [4:0] ACC_SH  = 5'b10_001;
    localparam logic [4:0] ACC_SW  = 5'b10_010;
    localparam logic [4:0] ACC_BAD = 5'b01_011;
    localparam logic [4:0] ACC_NON = 5'b00_010;

    rice_core_bus_arbiter #(.ADDRESS_WIDTH(32)) dut (
        .i_clk                  (i_clk),
        .i_rst_n                (i_rst_n),
        .i_fetch_valid          (i_fetch_valid),
        .o_fetch_ready          (o_fetch_ready),
        .i_fetch_address        (i_fetch_address),
        .o_fetch_response_valid (o_fetch_response_valid),
        .o_fetch_data           (o_fetch_data),
        .o_fetch_error          (o_fetch_error),
        .i_data_valid           (i_data_valid),
        .o_data_ready           (o_data_ready),
        .i_data_address         (i_data_address),
        .i_data_access          (i_data_access),
        .i_data_write_data      (i_data_write_data),
        .o_data_response_valid  (o_data_response_valid),
        .o_data_read_data       (o_data_read_data),
        .o_data_error           (o_data_error),
        .o_bus_valid            (o_bus_valid),
        .i_bus_ready            (i_bus_ready),
        .o_bus_address          (o_bus_address),
        .o_bus_write            (o_bus_write),
        .o_bus_strobe           (o_bus_strobe),
        .o_bus_write_data       (o_bus_write_data),
        .i_bus_response_valid   (i_bus_response_valid),
        .i_bus_read_data        (i_bus_read_data),
        .i_bus_error            (i_bus_error)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Advance one full cycle, landing on the falling edge.
    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " bus_valid"},   {31'h0, o_bus_valid}, 32'h0);
        check({tag, " bus_address"}, o_bus_address, 32'h0);
        check({tag, " bus_write"},   {31'h0, o_bus_write}, 32'h0);
        check({tag, " bus_strobe"},  {28'h0, o_bus_strobe}, 32'h0);
        check({tag, " bus_wdata"},   o_bus_write_data, 32'h0);
        check({tag, " f_rsp"},       {31'h0, o_fetch_response_valid}, 32'h0);
        check({tag, " f_data"},      o_fetch_data, 32'h0);
        check({tag, " f_err"},       {31'h0, o_fetch_error}, 32'h0);
        check({tag, " d_rsp"},       {31'h0, o_data_response_valid}, 32'h0);
        check({tag, " d_data"},      o_data_read_data, 32'h0);
        check({tag, " d_err"},       {31'h0, o_data_error}, 32'h0);
    endtask

    // Full legal transaction with an optional bus stall before i_bus_ready.
    task automatic txn(input string tag, input logic is_data, input logic [31:0] addr,
                       input logic [4:0] acc, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic bus_err, input int stall,
                       input logic [31:0] exp_addr, input logic [3:0] exp_strobe,
                       input logic exp_write, input logic [31:0] exp_wdata,
                       input logic [31:0] exp_rdata);
        if (is_data) begin
            i_data_valid      = 1'b1;
            i_data_address    = addr;
            i_data_access     = rice_core_memory_access'(acc);
            i_data_write_data = wdata;
        end else begin
            i_fetch_valid   = 1'b1;
            i_fetch_address = addr;
        end
        #1;
        check({tag, " ready"}, {31'h0, (is_data ? o_data_ready : o_fetch_ready)}, 32'h1);
        tick();
        i_fetch_valid = 1'b0;
        i_data_valid  = 1'b0;
        for (int s = 0; s <= stall; s++) begin
            check({tag, " bus_valid"}, {31'h0, o_bus_valid}, 32'h1);
            check({tag, " bus_addr"},  o_bus_address, exp_addr);
            if (s == stall) i_bus_ready = 1'b1;
            tick();
        end
        check({tag, " strobe"}, {28'h0, o_bus_strobe}, {28'h0, exp_strobe});
        check({tag, " write"},  {31'h0, o_bus_write}, {31'h0, exp_write});
        if (exp_write) check({tag, " wdata"}, o_bus_write_data, exp_wdata);
        i_bus_ready = 1'b0;
        check({tag, " bus_valid drop"}, {31'h0, o_bus_valid}, 32'h0);
        i_bus_response_valid = 1'b1;
        i_bus_read_data      = rdata;
        i_bus_error          = bus_err;
        tick();
        i_bus_response_valid = 1'b0;
        i_bus_error          = 1'b0;
        i_bus_read_data      = 32'h0;
        if (is_data) begin
            check({tag, " rsp_valid"}, {31'h0, o_data_response_valid}, 32'h1);
            check({tag, " rsp_err"},   {31'h0, o_data_error}, {31'h0, bus_err});
            if (!bus_err) check({tag, " rsp_data"}, o_data_read_data, exp_rdata);
            check({tag, " other_rsp"}, {31'h0, o_fetch_response_valid}, 32'h0);
        end else begin
            check({tag, " rsp_valid"}, {31'h0, o_fetch_response_valid}, 32'h1);
            check({tag, " rsp_err"},   {31'h0, o_fetch_error}, {31'h0, bus_err});
            if (!bus_err) check({tag, " rsp_data"}, o_fetch_data, exp_rdata);
            check({tag, " other_rsp"}, {31'h0, o_data_response_valid}, 32'h0);
        end
        tick();
        check({tag, " rsp_one_cycle"},
              {31'h0, (is_data ? o_data_response_valid : o_fetch_response_valid)}, 32'h0);
    endtask

    // Illegal request: error response next cycle, bus untouched.
    task automatic illegal(input string tag, input logic is_data, input logic [31:0] addr,
                           input logic [4:0] acc);
        if (is_data) begin
            i_data_valid   = 1'b1;
            i_data_address = addr;
            i_data_access  = rice_core_memory_access'(acc);
        end else begin
            i_fetch_valid   = 1'b1;
            i_fetch_address = addr;
        end
        #1;
        check({tag, " ready"}, {31'h0, (is_data ? o_data_ready : o_fetch_ready)}, 32'h1);
        tick();
        i_fetch_valid = 1'b0;
        i_data_valid  = 1'b0;
        check({tag, " bus_valid"}, {31'h0, o_bus_valid}, 32'h0);
        check({tag, " rsp_valid"},
              {31'h0, (is_data ? o_data_response_valid : o_fetch_response_valid)}, 32'h1);
        check({tag, " rsp_err"}, {31'h0, (is_data ? o_data_error : o_fetch_error)}, 32'h1);
        check({tag, " rsp_data"}, (is_data ? o_data_read_data : o_fetch_data), 32'h0);
        tick();
        check({tag, " bus_valid after"}, {31'h0, o_bus_valid}, 32'h0);
        check({tag, " rsp_one_cycle"},
              {31'h0, (is_data ? o_data_response_valid : o_fetch_response_valid)}, 32'h0);
    endtask

    initial begin
        i_rst_n              = 1'b0;
        i_fetch_valid        = 1'b0;
        i_fetch_address      = 32'h0;
        i_data_valid         = 1'b0;
        i_data_address       = 32'h0;
        i_data_access        = rice_core_memory_access'(ACC_LW);
        i_data_write_data    = 32'h0;
        i_bus_ready          = 1'b0;
        i_bus_response_valid = 1'b0;
        i_bus_read_data      = 32'h0;
        i_bus_error          = 1'b0;

        tick();
        tick();
        check_all_zero("reset");
        check("reset f_ready", {31'h0, o_fetch_ready}, 32'h0);
        check("reset d_ready", {31'h0, o_data_ready}, 32'h0);
        i_rst_n = 1'b1;
        tick();

        //   tag        data addr          acc      wdata         rdata         err stall exp_addr     strb     wr   exp_wdata     exp_rdata
        txn("fetch",    0, 32'h0000_0100, ACC_LW,  32'h0,        32'hDEAD_BEEF, 0, 0, 32'h0000_0100, 4'b1111, 0, 32'h0,        32'hDEAD_BEEF);
        txn("lb",       1, 32'h0000_0203, ACC_LB,  32'h0,        32'h80FF_FFFF, 0, 0, 32'h0000_0200, 4'b1000, 0, 32'h0,        32'hFFFF_FF80);
        txn("lbu",      1, 32'h0000_0203, ACC_LBU, 32'h0,        32'h80FF_FFFF, 0, 0, 32'h0000_0200, 4'b1000, 0, 32'h0,        32'h0000_0080);
        txn("sh",       1, 32'h0000_0402, ACC_SH,  32'h0000_1234, 32'hAAAA_AAAA, 0, 2, 32'h0000_0400, 4'b1100, 1, 32'h1234_1234, 32'h0);
        txn("lh",       1, 32'h0000_0202, ACC_LH,  32'h0,        32'h8001_7FFF, 0, 0, 32'h0000_0200, 4'b1100, 0, 32'h0,        32'hFFFF_8001);
        txn("lhu",      1, 32'h0000_0200, ACC_LHU, 32'h0,        32'h8001_7FFF, 0, 0, 32'h0000_0200, 4'b0011, 0, 32'h0,        32'h0000_7FFF);
        txn("sb",       1, 32'h0000_0101, ACC_SB,  32'h0000_00A5, 32'h0,        0, 1, 32'h0000_0100, 4'b0010, 1, 32'hA5A5_A5A5, 32'h0);
        txn("sw",       1, 32'h0000_0104, ACC_SW,  32'hCAFE_F00D, 32'h0,        0, 0, 32'h0000_0104, 4'b1111, 1, 32'hCAFE_F00D, 32'h0);

        illegal("lw_mis",    1, 32'h0000_0401, ACC_LW);
        illegal("lh_mis",    1, 32'h0000_0203, ACC_LH);
        illegal("mode_011",  1, 32'h0000_0200, ACC_BAD);
        illegal("type_none", 1, 32'h0000_0200, ACC_NON);
        illegal("fetch_mis", 0, 32'h0000_0102, ACC_LW);

        // Both requesters held valid for four back-to-back transactions.
        i_fetch_valid   = 1'b1;
        i_fetch_address = 32'h0000_0300;
        i_data_valid    = 1'b1;
        i_data_address  = 32'h0000_0500;
        i_data_access   = rice_core_memory_access'(ACC_LW);
        for (int k = 0; k < 4; k++) begin
            logic exp_data;
`ifdef RICE_CORE_BUS_ARBITER_ROUND_ROBIN_EN
            exp_data = (k % 2 == 0);
`else
            exp_data = 1'b1;
`endif
            #1;
            check($sformatf("arb%0d d_ready", k), {31'h0, o_data_ready},  {31'h0, exp_data});
            check($sformatf("arb%0d f_ready", k), {31'h0, o_fetch_ready}, {31'h0, !exp_data});
            tick();
            check($sformatf("arb%0d bus_addr", k), o_bus_address,
                  exp_data ? 32'h0000_0500 : 32'h0000_0300);
            i_bus_ready = 1'b1;
            tick();
            i_bus_ready          = 1'b0;
            i_bus_response_valid = 1'b1;
            i_bus_read_data      = 32'h1000_0000 + k;
            tick();
            i_bus_response_valid = 1'b0;
            check($sformatf("arb%0d d_rsp", k), {31'h0, o_data_response_valid}, {31'h0, exp_data});
            check($sformatf("arb%0d f_rsp", k), {31'h0, o_fetch_response_valid}, {31'h0, !exp_data});
            if (k == 3) begin
                i_fetch_valid = 1'b0;
                i_data_valid  = 1'b0;
            end
        end
        tick();

        // Reset while waiting for the bus response drops the transaction.
        i_fetch_valid   = 1'b1;
        i_fetch_address = 32'h0000_0600;
        tick();
        i_fetch_valid = 1'b0;
        i_bus_ready   = 1'b1;
        tick();
        i_bus_ready = 1'b0;
        i_rst_n     = 1'b0;
        tick();
        check_all_zero("mid_reset");
        i_rst_n = 1'b1;
        tick();
        check("post_reset no f_rsp", {31'h0, o_fetch_response_valid}, 32'h0);
        check("post_reset no bus",   {31'h0, o_bus_valid}, 32'h0);

        txn("fetch_after_reset", 0, 32'h0000_0700, ACC_LW, 32'h0, 32'h1357_9BDF, 0, 0,
            32'h0000_0700, 4'b1111, 0, 32'h0, 32'h1357_9BDF);
        txn("fetch_bus_err", 0, 32'h0000_0704, ACC_LW, 32'h0, 32'h0, 1, 0,
            32'h0000_0704, 4'b1111, 0, 32'h0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
